// File: rtl/scrypt_pkg.sv
// scrypt_pkg: shared widths, ROMix state encodings and Salsa20/8 helpers.
// Blocks are big-endian word arrays: word k of a 512-bit half sits at [511-32k -: 32].
package scrypt_pkg;
  localparam int BLOCK_W = 1024;
  localparam int HALF_W = 512;
  localparam int J_LSB = HALF_W - 32;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FILL_GO = 3'd1;
  localparam logic [2:0] FILL_WAIT = 3'd2;
  localparam logic [2:0] MIX_RD = 3'd3;
  localparam logic [2:0] MIX_GO = 3'd4;
  localparam logic [2:0] MIX_WAIT = 3'd5;
  localparam logic [2:0] DONE = 3'd6;
  // Quarter-round operand indices (a,b,c,d): four column rounds, then four row rounds.
  localparam logic [127:0] QR_IDX = {
    4'd0, 4'd4, 4'd8, 4'd12, 4'd5, 4'd9, 4'd13, 4'd1,
    4'd10, 4'd14, 4'd2, 4'd6, 4'd15, 4'd3, 4'd7, 4'd11,
    4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd4,
    4'd10, 4'd11, 4'd8, 4'd9, 4'd15, 4'd12, 4'd13, 4'd14};

  function automatic logic [HALF_W-1:0] salsa_dr(input logic [HALF_W-1:0] s);
    logic [31:0] w [16];
    logic [31:0] t;
    logic [3:0] a, b, c, d;
    logic [HALF_W-1:0] r;
    for (int k = 0; k < 16; k++) w[k] = s[HALF_W-1-32*k -: 32];
    for (int q = 0; q < 8; q++) begin
      {a, b, c, d} = QR_IDX[127-16*q -: 16];
      t = w[a] + w[d]; w[b] = w[b] ^ {t[24:0], t[31:25]};
      t = w[b] + w[a]; w[c] = w[c] ^ {t[22:0], t[31:23]};
      t = w[c] + w[b]; w[d] = w[d] ^ {t[18:0], t[31:19]};
      t = w[d] + w[c]; w[a] = w[a] ^ {t[13:0], t[31:14]};
    end
    for (int k = 0; k < 16; k++) r[HALF_W-1-32*k -: 32] = w[k];
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] wadd(input logic [HALF_W-1:0] a, input logic [HALF_W-1:0] b);
    logic [HALF_W-1:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = a[32*k +: 32] + b[32*k +: 32];
    return r;
  endfunction
endpackage

// File: rtl/scrypt_blockmix.sv
// scrypt_blockmix: BlockMix (r=1) with an iterative Salsa20/8, one double round per cycle.
// Ports: clk, n_rst (async active-low), enable (one-cycle start, data sampled then),
// data (input block), done (one-cycle pulse), out (result, valid while done is high).
// Latency from enable to done is 10 cycles inclusive.
module scrypt_blockmix
  import scrypt_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               enable,
  input  logic [BLOCK_W-1:0] data,
  output logic               done,
  output logic [BLOCK_W-1:0] out
);
  logic [HALF_W-1:0] x_q, x_d, orig_q, orig_d, b1_q, b1_d, y0_q, y0_d, dr, sum;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic [1:0] cnt_q, cnt_d;
  logic run_q, run_d, ph_q, ph_d, done_q, done_d;
  // orig holds the Salsa input so the final feed-forward add can be done after round 8.
  always_comb begin
    dr = salsa_dr(x_q);
    sum = wadd(dr, orig_q);
    x_d = x_q;
    orig_d = orig_q;
    b1_d = b1_q;
    y0_d = y0_q;
    cnt_d = cnt_q;
    run_d = run_q;
    ph_d = ph_q;
    done_d = 1'b0;
    out_d = out_q;
    if (enable && !run_q) begin
      x_d = data[BLOCK_W-1:HALF_W] ^ data[HALF_W-1:0];
      orig_d = data[BLOCK_W-1:HALF_W] ^ data[HALF_W-1:0];
      b1_d = data[HALF_W-1:0];
      cnt_d = 2'd0;
      ph_d = 1'b0;
      run_d = 1'b1;
    end else if (run_q) begin
      x_d = dr;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3 && !ph_q) begin
        y0_d = sum;
        x_d = sum ^ b1_q;
        orig_d = sum ^ b1_q;
        ph_d = 1'b1;
      end else if (cnt_q == 2'd3) begin
        out_d = {y0_q, sum};
        done_d = 1'b1;
        run_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      x_q <= '0;
      orig_q <= '0;
      b1_q <= '0;
      y0_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      ph_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q <= x_d;
      orig_q <= orig_d;
      b1_q <= b1_d;
      y0_q <= y0_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      ph_q <= ph_d;
      done_q <= done_d;
    end
  assign done = done_q;
  assign out = out_q;
endmodule

// File: rtl/scrypt_vram.sv
// scrypt_vram: single-port scratchpad, synchronous write, registered read (1-cycle latency).
// Ports: clk, we (write enable), addr, wdata, rdata (data for the address of the previous cycle).
module scrypt_vram #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH = 1024
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/scrypt_romix.sv
// scrypt_romix: scrypt ROMix (r=1): fill scratchpad V with N BlockMix states, then N data-dependent mixes.
// Ports: clk, n_rst (async active-low), data (block B, sampled on accept), enable (start, level-sampled in IDLE),
// busy (not IDLE), hash_out (held result), hash_done (one-cycle pulse on update).
// Optional: define SCRYPT_ROMIX_PERF_EN to add cycles[31:0], a saturating count of busy cycles of the last run.
module scrypt_romix
  import scrypt_pkg::*;
#(
  parameter int N_LOG2 = 10
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [BLOCK_W-1:0] data,
  input  logic               enable,
  output logic               busy,
  output logic [BLOCK_W-1:0] hash_out,
  output logic               hash_done
`ifdef SCRYPT_ROMIX_PERF_EN
  ,
  output logic [31:0]        cycles
`endif
);
  localparam logic [N_LOG2:0] LAST = {1'b0, {N_LOG2{1'b1}}};
  logic [2:0] state_q, state_d;
  logic [BLOCK_W-1:0] x_q, x_d, hash_out_q, hash_out_d, bm_out, rdata;
  logic [N_LOG2:0] i_q, i_d;
  logic [N_LOG2-1:0] ram_addr;
  logic hash_done_q, hash_done_d, bm_en_q, bm_en_d, bm_done, ram_we;
  // In the mix phase X absorbs V[j] in MIX_GO, so X itself is always the BlockMix input
  // and stays stable from the registered enable pulse until done.
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    i_d = i_q;
    hash_out_d = hash_out_q;
    hash_done_d = 1'b0;
    bm_en_d = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        x_d = data;
        i_d = '0;
        state_d = FILL_GO;
      end
      FILL_GO: begin
        bm_en_d = 1'b1;
        state_d = FILL_WAIT;
      end
      FILL_WAIT: if (bm_done) begin
        x_d = bm_out;
        i_d = (i_q == LAST) ? '0 : i_q + 1'b1;
        state_d = (i_q == LAST) ? MIX_RD : FILL_GO;
      end
      MIX_RD: state_d = MIX_GO;
      MIX_GO: begin
        x_d = x_q ^ rdata;
        bm_en_d = 1'b1;
        state_d = MIX_WAIT;
      end
      MIX_WAIT: if (bm_done) begin
        x_d = bm_out;
        i_d = i_q + 1'b1;
        state_d = (i_q == LAST) ? DONE : MIX_RD;
        hash_out_d = (i_q == LAST) ? bm_out : hash_out_q;
        hash_done_d = (i_q == LAST);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      x_q <= '0;
      i_q <= '0;
      hash_out_q <= '0;
      hash_done_q <= 1'b0;
      bm_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      i_q <= i_d;
      hash_out_q <= hash_out_d;
      hash_done_q <= hash_done_d;
      bm_en_q <= bm_en_d;
    end
  assign ram_we = (state_q == FILL_GO);
  assign ram_addr = (state_q == MIX_RD) ? x_q[J_LSB +: N_LOG2] : i_q[N_LOG2-1:0];
  assign busy = (state_q != IDLE);
  assign hash_out = hash_out_q;
  assign hash_done = hash_done_q;
  scrypt_vram #(.DEPTH_LOG2(N_LOG2), .WIDTH(BLOCK_W)) u_vram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(x_q), .rdata(rdata)
  );
  scrypt_blockmix u_bm (
    .clk(clk), .n_rst(n_rst), .enable(bm_en_q), .data(x_q), .done(bm_done), .out(bm_out)
  );
`ifdef SCRYPT_ROMIX_PERF_EN
  logic [31:0] cycles_q, cycles_d;
  always_comb cycles_d = (state_q == IDLE) ? (enable ? 32'd0 : cycles_q)
                                           : (&cycles_q ? cycles_q : cycles_q + 32'd1);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cycles_q <= '0;
    else cycles_q <= cycles_d;
  assign cycles = cycles_q;
`endif
endmodule

// File: doc/scrypt_romix.md
Name: scrypt_romix

Overview:
- Implements the scrypt ROMix step (r=1) around one `scrypt_blockmix` instance.
- Phase 1 (fill): writes N successive BlockMix states into a scratchpad V.
- Phase 2 (mix): performs N data-dependent reads of V, XORs each into the running state, and re-mixes.
- Sits directly upstream of `scrypt_blockmix`, which it drives; its own input comes from the PBKDF2 front stage and its output goes to the PBKDF2 back stage.

Parameters:
- N_LOG2, 10, log2 of scrypt cost N. V depth = 2^N_LOG2 entries of 1024 bits. Legal range 1..10.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- data  input  1024  input block B; sampled only on the cycle `enable` is accepted
- enable  input  1  start request, level-sampled in IDLE
- busy  output  1  high in every state except IDLE
- hash_out  output  1024  ROMix result; held until the next completion
- hash_done  output  1  one-cycle pulse when hash_out is updated

Interface rules: one clock, `clk`. Reset is `n_rst`, asynchronous and active-low.

Behaviour:
- Reset values: state=IDLE, busy=0, hash_done=0, hash_out=0, X=0, i=0. V contents are not reset and are undefined.
- Internal state: X[1023:0] running state; counter i[N_LOG2:0]; j = X[480 +: N_LOG2], the low bits of word 0 of the second 64-byte half X[511:0].
- BlockMix handshake:
  - bm_enable is asserted for exactly one cycle while bm_data is stable.
  - The block then waits for bm_done. bm_out is captured on the bm_done cycle.
  - bm_enable is never re-asserted before bm_done.
- V RAM: single port, synchronous write, synchronous read with 1-cycle read latency.
- States and transitions:
  - IDLE: if enable=1, X<=data, i<=0, go to FILL_GO. Otherwise stay.
  - FILL_GO: V[i]<=X; bm_data=X; bm_enable=1; go to FILL_WAIT.
  - FILL_WAIT: on bm_done, X<=bm_out and i<=i+1. If i==N-1, clear i<=0 and go to MIX_RD; else go to FILL_GO.
  - MIX_RD: RAM address = j from the current X; go to MIX_GO.
  - MIX_GO: bm_data = X ^ rdata; bm_enable=1; go to MIX_WAIT.
  - MIX_WAIT: on bm_done, X<=bm_out and i<=i+1. If i==N-1, go to DONE; else go to MIX_RD.
  - DONE: hash_out<=X registered on DONE entry; hash_done=1 for this cycle only; go to IDLE.
- Latency: with BlockMix latency Lb (enable to done, inclusive), enable-accept to hash_done = 1 + N*(1+Lb) + N*(2+Lb) cycles.
- Counter i is N_LOG2+1 bits wide, so the N-1 comparison never wraps. No arithmetic beyond increment and XOR.
- Boundaries:
  - enable while busy=1 is ignored; no queueing.
  - enable held high across DONE: a new run starts on the IDLE cycle that follows, with fresh data.
  - Reset mid-operation: returns to IDLE within the reset assertion. bm_enable is dropped. hash_done is never pulsed for the aborted run.
  - j may equal any index including 0 and N-1. Repeated j values are legal.
  - data changing after acceptance has no effect.

Optional Feature:
- Macro: SCRYPT_ROMIX_PERF_EN.
- Defined: adds output `cycles[31:0]`.
  - Reset to 0; cleared on enable acceptance; increments every non-IDLE cycle, saturating at 32'hFFFFFFFF.
  - Frozen at the DONE value until the next acceptance.
- Undefined: the port and counter are absent, and functional behaviour is identical.

Decomposition:
- Shared package `scrypt_pkg`: the ROMix state enum (IDLE, FILL_GO, FILL_WAIT, MIX_RD, MIX_GO, MIX_WAIT, DONE) and constants BLOCK_W=1024 and HALF_W=512.
- Sub-module `scrypt_vram` (parameters DEPTH_LOG2 and WIDTH): single-port synchronous RAM with 1-cycle read, instantiated once.
- The existing `scrypt_blockmix` is instantiated once.

Test Plan:
- N_LOG2=2, data=1024'h0, enable pulsed 1 cycle: exactly 8 bm_enable pulses, 4 V writes at addresses 0..3, then exactly one hash_done; hash_out equals the golden C model.
- N_LOG2=2, data=incrementing bytes 0x00..0x7F: each phase-2 read address equals X[481:480] before that read; hash_out matches the model; latency equals 1+4*(1+Lb)+4*(2+Lb).
- enable held high for the entire run, with data changed mid-run: the result uses only the accepted data, and a second run starts on the IDLE cycle after DONE.
- n_rst asserted during MIX_WAIT of run 1, then a new run with data=all-ones: no hash_done for run 1, and run 2 output matches the model.
- Two back-to-back runs with different data: hash_out holds the run-1 value until run-2 hash_done; busy=0 only in IDLE.
- SCRYPT_ROMIX_PERF_EN defined, N_LOG2=2: cycles equals the measured enable-to-done latency and is held afterwards.
